// File: rtl/mvm_pkg.sv
// mvm_pkg: shared widths, types and saturating helpers for the MVM dot-product unit
package mvm_pkg;
  localparam int N_DEF = 8;
  localparam int S_DEF = 4;
  typedef logic [N_DEF-1:0] elem_t;
  typedef logic [2*N_DEF-1:0] prod_t;
  localparam elem_t N_MAX = '1;
  function automatic elem_t sat_prod(input prod_t p);
    return |p[2*N_DEF-1:N_DEF] ? N_MAX : p[N_DEF-1:0];
  endfunction
  function automatic elem_t sat_addN(input elem_t a, input elem_t b);
    logic [N_DEF:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[N_DEF] ? N_MAX : s[N_DEF-1:0];
  endfunction
endpackage

// File: rtl/mvm_sat_mul.sv
// mvm_sat_mul: one unsigned multiply clamped to the element width
module mvm_sat_mul #(
  parameter int N = mvm_pkg::N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] m
);
  logic [2*N-1:0] p;
  assign p = a * b;
  assign m = |p[2*N-1:N] ? '1 : p[N-1:0];
endmodule

// File: rtl/mvm_normal_mul_unit.sv
// mvm_normal_mul_unit: registered inputs feeding a one-cycle saturating dot product
module mvm_normal_mul_unit
  import mvm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int S = S_DEF
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [S*N-1:0] w,
  input  logic [S*N-1:0] u,
  output logic [N-1:0] v
);
  logic [S*N-1:0] w_q, u_q, w_d, u_d;
  logic [N-1:0] m [S];
  logic [N-1:0] acc [S];
  assign w_d = reset ? '0 : w;
  assign u_d = reset ? '0 : u;
  // capture both vectors every edge; reset clears them so v reads zero
  always_ff @(posedge CLOCK_50) begin
    w_q <= w_d;
    u_q <= u_d;
  end
  assign acc[0] = m[0];
  for (genvar i = 0; i < S; i++) begin : g_lane
    mvm_sat_mul #(.N(N)) u_mul (
      .a(w_q[i*N +: N]),
      .b(u_q[i*N +: N]),
      .m(m[i])
    );
    if (i > 0) begin : g_add
      logic [N:0] sum;
      assign sum = {1'b0, acc[i-1]} + {1'b0, m[i]};
      assign acc[i] = sum[N] ? '1 : sum[N-1:0];
    end
  end
  assign v = acc[S-1];
endmodule

// File: tb/tb_mvm_normal_mul_unit.sv
// tb_mvm_normal_mul_unit: directed and random checks of the saturating dot product
module tb_mvm_normal_mul_unit;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [31:0] w = 32'h0403_0201;
  logic [31:0] u = 32'h0807_0605;
  logic [7:0] v;
  int vecs = 0;
  int errs = 0;

  mvm_normal_mul_unit #(.N(8), .S(4)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .w(w),
    .u(u),
    .v(v)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] p;
    logic [8:0] s;
    logic [7:0] m, acc;
    acc = 8'd0;
    for (int i = 0; i < 4; i++) begin
      p = a[i*8 +: 8] * b[i*8 +: 8];
      m = |p[15:8] ? 8'hFF : p[7:0];
      if (i == 0) acc = m;
      else begin
        s = {1'b0, acc} + {1'b0, m};
        acc = s[8] ? 8'hFF : s[7:0];
      end
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp);
    vecs++;
    assert (v === exp) else begin
      errs++;
      $error("FAIL %s: v=%0d expected %0d", tag, v, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    @(negedge CLOCK_50);
    w = {a3, a2, a1, a0};
    u = {b3, b2, b1, b0};
  endtask

  task automatic step(input string tag, input logic [7:0] a0, a1, a2, a3,
                      input logic [7:0] b0, b1, b2, b3, input logic [7:0] exp);
    drive(a0, a1, a2, a3, b0, b1, b2, b3);
    @(posedge CLOCK_50);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    @(posedge CLOCK_50);
    #1;
    chk("reset_edge1", 8'd0);
    @(posedge CLOCK_50);
    #1;
    chk("reset_edge2", 8'd0);
    drive(1, 2, 3, 4, 5, 6, 7, 8);
    reset = 1'b0;
    #1;
    chk("hold_before_capture", 8'd0);
    @(posedge CLOCK_50);
    #1;
    chk("basic", 8'd70);
    step("prod_255", 15, 0, 0, 0, 17, 0, 0, 0, 8'd255);
    step("prod_256", 16, 0, 0, 0, 16, 0, 0, 0, 8'd255);
    step("prod_400", 20, 0, 0, 0, 20, 0, 0, 0, 8'd255);
    step("prod_small", 15, 0, 0, 0, 16, 0, 0, 0, 8'd240);
    step("zero_operand", 0, 200, 0, 0, 255, 0, 0, 0, 8'd0);
    step("sum_255", 128, 127, 0, 0, 1, 1, 0, 0, 8'd255);
    step("sum_256", 100, 100, 56, 1, 1, 1, 1, 0, 8'd255);
    step("sum_400", 10, 10, 10, 10, 10, 10, 10, 10, 8'd255);
    step("sum_254", 100, 100, 54, 3, 1, 1, 1, 0, 8'd254);
    step("sticky_sat", 255, 0, 0, 1, 255, 0, 0, 1, 8'd255);
    step("last_lane", 0, 0, 0, 9, 0, 0, 0, 9, 8'd81);
    step("prepare_mid", 3, 3, 3, 3, 4, 4, 4, 4, 8'd48);
    drive(9, 9, 9, 9, 9, 9, 9, 9);
    reset = 1'b1;
    #1;
    chk("hold_before_reset", 8'd48);
    @(posedge CLOCK_50);
    #1;
    chk("mid_reset", 8'd0);
    drive(2, 0, 0, 0, 3, 0, 0, 0);
    reset = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("first_capture", 8'd6);
    for (int t = 0; t < 100; t++) begin
      logic [31:0] rw, ru;
      for (int i = 0; i < 4; i++) begin
        rw[i*8 +: 8] = 8'($urandom_range(10, 0));
        ru[i*8 +: 8] = 8'($urandom_range(10, 0));
      end
      @(negedge CLOCK_50);
      w = rw;
      u = ru;
      @(posedge CLOCK_50);
      #1;
      chk("random", model(rw, ru));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mvm_normal_mul_unit.md
MVM_NORMAL_MUL_UNIT -- requirements
Module: mvm_normal_mul_unit

Interface
REQ-001 Parameter N, default 8: unsigned element width in bits (N >= 2).
REQ-002 Parameter S, default 4: vector length, i.e. number of elements per bus (S >= 1).
REQ-003 CLOCK_50  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: reset, synchronous and active-high.
REQ-005 w  input  S*N: weight vector; element i occupies bits [(i+1)*N-1 : i*N]; unsigned.
REQ-006 u  input  S*N: input vector, same packing as w; unsigned.
REQ-007 v  output  N: saturated unsigned dot product of the registered w and u.

Function
REQ-008 w and u SHALL be captured into internal registers w_q and u_q on every rising edge of CLOCK_50 while reset is low; there is no enable and no handshake.
REQ-009 v SHALL be purely combinational from w_q and u_q.
- Latency: inputs stable at edge k appear on v after edge k, i.e. 1 cycle.
- v SHALL NOT change between edges.
REQ-010 Per element: compute p_i = w_q[i] * u_q[i] at 2N bits, unsigned.
REQ-011 Product saturation: m_i = 2^N-1 if p_i[2N-1:N] is nonzero, else m_i = p_i[N-1:0].
REQ-012 Accumulation SHALL proceed in index order:
- acc = m_0;
- for i = 1..S-1, acc = sat_add(acc, m_i), where sat_add forms an N+1-bit sum and yields 2^N-1 if bit N is set, else the low N bits.
REQ-013 v = final acc. Saturation is sticky: once acc reaches 2^N-1, later adds SHALL keep it at 2^N-1.
REQ-014 Boundaries:
- Product exactly 2^N-1 SHALL pass unsaturated.
- Product of 2^N SHALL saturate.
- A sum of exactly 2^N-1 SHALL pass unsaturated.
- A sum of 2^N SHALL saturate.
- Any zero operand SHALL give a zero product.
REQ-015 No X propagation: v SHALL be fully defined whenever w_q and u_q are defined.

Reset
REQ-016 While reset is high at a rising edge, w_q and u_q SHALL be cleared to 0, so v = 0 after that edge.
REQ-017 When reset is asserted mid-operation, it SHALL override capture on that edge.
REQ-018 The first capture SHALL occur on the first rising edge with reset low.

Structure
REQ-019 A shared package mvm_pkg SHALL hold:
- the default N and S;
- elem_t (N bits) and prod_t (2N bits);
- constant N_MAX = all ones;
- functions sat_prod and sat_addN.
REQ-020 Sub-module mvm_sat_mul #(N) SHALL perform one saturating multiply.
- The top SHALL instantiate S copies via generate.
- The top SHALL perform the saturating add chain and own the input registers.
REQ-021 There SHALL be no latches and no multicycle paths; the dot product SHALL complete in one cycle of combinational logic.

Verification (N=8, S=4)
REQ-022 Reset: hold reset high for 2 edges -> v = 0 after the first edge.
REQ-023 Basic: w={1,2,3,4}, u={5,6,7,8} -> v = 70 one edge after capture; before that edge v holds its previous value.
REQ-024 Product boundary, other elements 0:
- w0=15, u0=17 -> v = 255 (product 255, unsaturated);
- w0=16, u0=16 -> v = 255 (product 256, saturated);
- w0=20, u0=20 -> v = 255.
REQ-025 Sum boundary:
- products {128,127,0,0} (w={128,127,0,0}, u={1,1,0,0}) -> v = 255;
- w={100,100,56,1}, u={1,1,1,0} -> v = 255 (sum 256, saturated);
- w={10,10,10,10}, u={10,10,10,10} -> v = 255.
REQ-026 Random: 100 trials with elements uniform in 0..10.
- Drive inputs on the falling edge.
- Check v against the REQ-010..013 model just after the next rising edge.
- Any mismatch fails the test.
